mpadder_arbiter: RTL
====================

Name: mpadder_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 1027-bit multi-precision adder/subtractor between N requesters (e.g. Montgomery loop, final reduction, exponentiation control).
- Captures the winner's operands and pulses the adder start, then waits for adder done.
- Returns the 1028-bit result to the winner.
- A watchdog flags an adder that never completes.

Parameters:
- N, 4, number of requesters (2..8).
- W, 1027, operand width; result width is W+1.
- MAX_WAIT, 16, cycles allowed in WAIT before timeout.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N  per-requester request; held high until own rsp_valid.
- sub  in  N  per-requester op select: 1 = subtract (a-b), 0 = add.
- op_a  in  N*W  flattened operand A; requester i at [W*i +: W].
- op_b  in  N*W  flattened operand B; same packing.
- gnt  out  N  one-hot grant, high from capture until rsp cycle inclusive.
- rsp_valid  out  N  one-cycle pulse to the granted requester.
- rsp_err  out  1  high with rsp_valid when the op timed out.
- rsp_result  out  W+1  result, valid only while rsp_valid is nonzero.
- add_start  out  1  one-cycle start pulse to the adder.
- add_subtract  out  1  registered op select to the adder.
- add_in_a  out  W  registered operand A.
- add_in_b  out  W  registered operand B.
- add_result  in  W+1  adder result.
- add_done  in  1  adder completion pulse.
- busy  out  1  high in any state except IDLE.
- err_sticky  out  1  set on any timeout; cleared only by reset.

Behaviour:
- Reset (async, any state): all outputs 0, state IDLE, rr pointer 0, wait counter 0, operand registers 0.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, no req: stay in IDLE, outputs quiet.
- IDLE, req != 0:
  - Winner = first set bit searching from pointer upward, wrapping mod N.
  - Next edge: gnt <= onehot(winner); add_in_a, add_in_b, add_subtract <= winner's inputs; go to ISSUE.
- ISSUE: add_start = 1 for exactly this cycle; go to WAIT; wait counter cleared.
- WAIT, add_done = 1: latch add_result into rsp_result; go to RESP.
- WAIT, add_done = 0: increment wait counter.
- WAIT timeout: when the counter reaches MAX_WAIT-1 with no done, latch rsp_result = 0, set rsp_err and err_sticky, go to RESP.
- RESP:
  - rsp_valid = gnt for one cycle; rsp_err is valid in this cycle.
  - Pointer <= (winner+1) mod N.
  - Next edge: gnt, rsp_valid, rsp_err <= 0; go to IDLE.
- Operand registers hold their value from capture until the next capture, so adder inputs are stable for the whole operation.
- Requester inputs are sampled only at capture. Later changes to op_a, op_b or sub are ignored.
- Minimum throughput: req at cycle 0 -> gnt at edge 1 -> add_start in cycle 1 -> done earliest in cycle 2 -> rsp_valid cycle 3 -> IDLE cycle 4.
  - A requester holding req back-to-back re-arbitrates in cycle 4, with its priority now lowest.
- Boundary conditions:
  - add_done in IDLE, ISSUE or RESP is ignored.
  - add_done in the timeout cycle: done wins, rsp_err = 0.
  - Winner drops req mid-op: the op still completes and rsp_valid still pulses; the requester ignores it.
  - Req from a non-winner during an op: held, served in round-robin order afterwards.
  - Simultaneous requests from all N: each is served exactly once per N operations.
  - Reset mid-op: the operation is abandoned and no rsp_valid is issued. The adder is reset by its own resetn in the top level.
- gnt is never more than one-hot. rsp_valid is always a subset of gnt.

Decomposition:
- Shared package (mpa_pkg): MPA_W = 1027 and the state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3). The same package is used by the Montgomery controller.
- Sub-module rr_select: combinational, inputs req[N] and pointer, output one-hot winner plus a valid flag. Verified standalone; everything else is in mpadder_arbiter.

Test Plan:
- Single add: req=0001, sub=0, a=5, b=7, adder model done 2 cycles after start -> add_start exactly 1 cycle; rsp_valid=0001 with rsp_result=12, rsp_err=0; busy returns to 0.
- Subtract path: req=0100, sub[2]=1, a=2^1026, b=1 -> add_subtract=1, add_in_a/add_in_b match captured values; rsp_result equals model output; gnt=0100 throughout.
- Round robin: req=1111 held continuously, pointer reset to 0 -> grant order 0,1,2,3,0; no requester granted twice before all others.
- Timeout: adder never asserts done -> after MAX_WAIT=16 WAIT cycles rsp_valid pulses with rsp_err=1, rsp_result=0, err_sticky=1; the next request completes normally with err_sticky still 1.
- Operand stability: change op_a[0] from 5 to 9 one cycle after grant -> add_in_a stays 5 until RESP, result uses 5.
- Reset mid-WAIT: assert reset for 1 cycle in WAIT -> gnt, busy, add_start, rsp_valid = 0 immediately (async); no stray rsp_valid afterwards; pointer = 0.

Source files
------------

// File: rtl/mpa_pkg.sv
// Shared definitions for the multi-precision adder datapath and its controllers:
// operand width and the arbiter/sequencer state encoding.
package mpa_pkg;

    localparam int MPA_W = 1027;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mpa_state_e;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first asserted request at or above the
// pointer, wrapping modulo N. Returns a one-hot winner and a valid flag.
module rr_select #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win_oh,
    output logic          win_vld
);

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        win_oh  = '0;
        win_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (!win_vld && req[j]) begin
                win_oh[j] = 1'b1;
                win_vld   = 1'b1;
            end else begin
                win_oh = win_oh;
            end
        end
    end

endmodule

// File: rtl/mpadder_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-precision adder between N
// requesters, with a watchdog on adder completion.
module mpadder_arbiter
    import mpa_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = MPA_W,
    parameter int MAX_WAIT = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   sub,
    input  logic [N*W-1:0] op_a,
    input  logic [N*W-1:0] op_b,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rsp_valid,
    output logic           rsp_err,
    output logic [W:0]     rsp_result,
    output logic           add_start,
    output logic           add_subtract,
    output logic [W-1:0]   add_in_a,
    output logic [W-1:0]   add_in_b,
    input  logic [W:0]     add_result,
    input  logic           add_done,
    output logic           busy,
    output logic           err_sticky
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_WAIT + 1);

    mpa_state_e    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [W:0]    rsp_result_q, rsp_result_d;
    logic          add_start_q, add_start_d;
    logic          sub_q, sub_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          busy_q, busy_d;
    logic          err_sticky_q, err_sticky_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx_q, idx_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    logic [N-1:0]  win_oh_s;
    logic          win_vld_s;
    logic [PW-1:0] win_idx_s;
    logic [W-1:0]  a_sel_s;
    logic [W-1:0]  b_sel_s;
    logic          sub_sel_s;
    logic          timeout_s;

    rr_select #(
        .N  (N),
        .PW (PW)
    ) u_rr_select (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (win_oh_s),
        .win_vld (win_vld_s)
    );

    // One-hot to index and AND-OR operand mux, avoiding variable part-selects on the wide buses.
    always_comb begin
        win_idx_s = '0;
        a_sel_s   = '0;
        b_sel_s   = '0;
        for (int i = 0; i < N; i++) begin
            win_idx_s = win_idx_s | (win_oh_s[i] ? PW'(i) : PW'(0));
            a_sel_s   = a_sel_s | (op_a[i*W +: W] & {W{win_oh_s[i]}});
            b_sel_s   = b_sel_s | (op_b[i*W +: W] & {W{win_oh_s[i]}});
        end
        sub_sel_s = |(sub & win_oh_s);
    end

    assign timeout_s = (state_q == ST_WAIT) && !add_done && (wait_cnt_q == CW'(MAX_WAIT - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld_s) state_d = ST_ISSUE;
                else           state_d = ST_IDLE;
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (add_done || timeout_s) state_d = ST_RESP;
                else                       state_d = ST_WAIT;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; a done in the timeout cycle takes precedence.
    always_comb begin
        gnt_d        = gnt_q;
        rsp_valid_d  = '0;
        rsp_err_d    = 1'b0;
        rsp_result_d = rsp_result_q;
        add_start_d  = 1'b0;
        sub_d        = sub_q;
        a_d          = a_q;
        b_d          = b_q;
        err_sticky_d = err_sticky_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        wait_cnt_d   = wait_cnt_q;
        busy_d       = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (win_vld_s) begin
                    gnt_d       = win_oh_s;
                    idx_d       = win_idx_s;
                    a_d         = a_sel_s;
                    b_d         = b_sel_s;
                    sub_d       = sub_sel_s;
                    add_start_d = 1'b1;
                end else begin
                    gnt_d = '0;
                end
            end
            ST_ISSUE: wait_cnt_d = '0;
            ST_WAIT: begin
                if (add_done) begin
                    rsp_result_d = add_result;
                    rsp_valid_d  = gnt_q;
                end else if (timeout_s) begin
                    rsp_result_d = '0;
                    rsp_valid_d  = gnt_q;
                    rsp_err_d    = 1'b1;
                    err_sticky_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                gnt_d = '0;
                if (idx_q == PW'(N - 1)) ptr_d = '0;
                else                     ptr_d = idx_q + PW'(1);
            end
            default: gnt_d = '0;
        endcase
    end

    // Output, operand and bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
            add_start_q  <= 1'b0;
            sub_q        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            busy_q       <= 1'b0;
            err_sticky_q <= 1'b0;
            ptr_q        <= '0;
            idx_q        <= '0;
            wait_cnt_q   <= '0;
        end else begin
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_result_q <= rsp_result_d;
            add_start_q  <= add_start_d;
            sub_q        <= sub_d;
            a_q          <= a_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            err_sticky_q <= err_sticky_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign gnt          = gnt_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_result   = rsp_result_q;
    assign add_start    = add_start_q;
    assign add_subtract = sub_q;
    assign add_in_a     = a_q;
    assign add_in_b     = b_q;
    assign busy         = busy_q;
    assign err_sticky   = err_sticky_q;

endmodule
